// File: rtl/data_mem_ctrl.sv
// Data-memory access sequencer between the execute stage and the data memory.
// Latches one load/store, runs a req/ack handshake with timeout, and returns load data to write-back.
`ifndef A_BITS
`define A_BITS 32
`endif
`ifndef D_BITS
`define D_BITS 32
`endif

module data_mem_ctrl #(
    parameter int ADDR_W  = `A_BITS,
    parameter int DATA_W  = `D_BITS,
    parameter int TIMEOUT = 15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ex_read_i,
    input  logic              ex_write_i,
    input  logic [ADDR_W-1:0] ex_addr_i,
    input  logic [DATA_W-1:0] ex_wdata_i,
    input  logic [2:0]        ex_dest_i,
    output logic              stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              wb_valid_o,
    output logic [2:0]        wb_dest_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic              err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } state_e;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_e              state_q;
    logic [7:0]          cnt_q;
    logic                req_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [2:0]          dest_q;
    logic                wb_valid_q;
    logic [2:0]          wb_dest_q;
    logic [DATA_W-1:0]   wb_data_q;
    logic                err_q;

    // Access sequencer: latches the request, counts WAIT cycles, registers all memory/write-back outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            dest_q     <= 3'd0;
            wb_valid_q <= 1'b0;
            wb_dest_q  <= 3'd0;
            wb_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            wb_valid_q <= 1'b0;
            err_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    // A simultaneous read and write resolves to the write.
                    if (ex_read_i || ex_write_i) begin
                        we_q    <= ex_write_i;
                        addr_q  <= ex_addr_i;
                        wdata_q <= ex_wdata_i;
                        dest_q  <= ex_dest_i;
                        req_q   <= 1'b1;
                        cnt_q   <= 8'd0;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_ack_i) begin
                        req_q   <= 1'b0;
                        state_q <= IDLE;
                        if (!we_q) begin
                            wb_valid_q <= 1'b1;
                            wb_data_q  <= mem_rdata_i;
                            wb_dest_q  <= dest_q;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        req_q   <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= ERR;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ERR: begin
                    state_q <= IDLE;
                end
                default: begin
                    req_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Pipeline freeze: new request in IDLE, or WAIT without ack; never while reset is held.
    always_comb begin
        stall_o = 1'b0;
        if (!rst_i) begin
            stall_o = 1'b0;
        end else if (state_q == IDLE) begin
            stall_o = ex_read_i | ex_write_i;
        end else if (state_q == WAIT) begin
            stall_o = ~mem_ack_i;
        end else begin
            stall_o = 1'b0;
        end
    end

    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign wb_valid_o  = wb_valid_q;
    assign wb_dest_o   = wb_dest_q;
    assign wb_data_o   = wb_data_q;
    assign err_o       = err_q;

endmodule
